// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction-fetch stage: PC, ROM address, IF/ID register
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_start           leave IDLE and begin fetching
//   i_stall           hold PC and IF/ID register
//   i_branch_take     taken branch; target = o_pc_plus1 + i_branch_off
//   i_branch_off      signed word offset (16 bits)
//   i_jump            jump request; target = i_jump_tgt[ADDR_WIDTH-1:0]
//   i_jump_tgt        26-bit jump target
//   o_rom_addr        ROM word address (current PC)
//   i_rom_instr       ROM read data for o_rom_addr (combinational)
//   o_instr           IF/ID instruction
//   o_pc_plus1        IF/ID PC+1 of o_instr
//   o_valid           IF/ID holds a real instruction
//   o_halted          HALT opcode fetched; stage frozen until reset
module instr_fetch #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]            HALT_OP     = 6'b111111
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_branch_take,
  input  logic [15:0]            i_branch_off,
  input  logic                   i_jump,
  input  logic [25:0]            i_jump_tgt,
  output logic [ADDR_WIDTH-1:0]  o_rom_addr,
  input  logic [INSTR_WIDTH-1:0] i_rom_instr,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus1,
  output logic                   o_valid,
  output logic                   o_halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [ADDR_WIDTH-1:0]  pc_plus1_d;
  logic                   valid_d;

  logic [ADDR_WIDTH-1:0]    pc_inc;
  logic [ADDR_WIDTH+15:0]   branch_sum;
  logic [ADDR_WIDTH-1:0]    branch_tgt;
  logic                     is_halt_op;
  logic                     unused_bits;

  // PC arithmetic wraps modulo 2^ADDR_WIDTH with no overflow flag.
  assign pc_inc = pc_q + 1'b1;

  // Sign-extend the offset past ADDR_WIDTH, then keep only the low bits so
  // the target truncates whatever the relative widths are.
  assign branch_sum = {16'b0, o_pc_plus1}
                    + {{ADDR_WIDTH{i_branch_off[15]}}, i_branch_off};
  assign branch_tgt = branch_sum[ADDR_WIDTH-1:0];

  assign is_halt_op  = (i_rom_instr[INSTR_WIDTH-1 -: 6] == HALT_OP);
  assign unused_bits = ^{branch_sum[ADDR_WIDTH+15:ADDR_WIDTH],
                         i_jump_tgt[25:ADDR_WIDTH]};

  assign o_rom_addr = pc_q;
  assign o_halted   = (state_q == S_HALT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      o_instr    <= '0;
      o_pc_plus1 <= '0;
      o_valid    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      o_instr    <= instr_d;
      o_pc_plus1 <= pc_plus1_d;
      o_valid    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = o_instr;
    pc_plus1_d = o_pc_plus1;
    valid_d    = o_valid;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        // Redirects outrank stall; both insert a bubble and keep IF/ID data.
        if (i_jump) begin
          pc_d    = i_jump_tgt[ADDR_WIDTH-1:0];
          valid_d = 1'b0;
        end else if (i_branch_take) begin
          pc_d    = branch_tgt;
          valid_d = 1'b0;
        end else if (!i_stall) begin
          instr_d    = i_rom_instr;
          pc_plus1_d = pc_inc;
          valid_d    = 1'b1;
          // The HALT word itself is delivered; the PC stays on it.
          if (is_halt_op) state_d = S_HALT;
          else            pc_d    = pc_inc;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, br, jump;
  logic [15:0] off;
  logic [25:0] tgt;
  logic [15:0] rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] instr;
  logic [15:0] pp1;
  logic        valid, halted;

  logic [31:0] rom [0:65535];

  always #5 clk = ~clk;

  assign rom_instr = rom[rom_addr];

  instr_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stall       (stall),
    .i_branch_take (br),
    .i_branch_off  (off),
    .i_jump        (jump),
    .i_jump_tgt    (tgt),
    .o_rom_addr    (rom_addr),
    .i_rom_instr   (rom_instr),
    .o_instr       (instr),
    .o_pc_plus1    (pp1),
    .o_valid       (valid),
    .o_halted      (halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: started/halted flags plus the architectural values.
  logic [15:0] m_pc, m_pp1;
  logic [31:0] m_instr;
  logic        m_valid, m_run, m_halt;

  task automatic model_reset();
    m_pc = 16'h0; m_pp1 = 16'h0; m_instr = 32'h0;
    m_valid = 1'b0; m_run = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (m_halt) begin
      m_valid = 1'b0;
    end else if (!m_run) begin
      m_valid = 1'b0;
      if (start) m_run = 1'b1;
    end else if (jump) begin
      m_pc = tgt[15:0];
      m_valid = 1'b0;
    end else if (br) begin
      m_pc = m_pp1 + off;
      m_valid = 1'b0;
    end else if (!stall) begin
      w = rom[m_pc];
      m_instr = w;
      m_pp1 = m_pc + 16'd1;
      m_valid = 1'b1;
      if (w[31:26] == 6'h3F) m_halt = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".pc"},     {16'h0, rom_addr}, {16'h0, m_pc});
    check({tag, ".instr"},  instr,             m_instr);
    check({tag, ".pp1"},    {16'h0, pp1},      {16'h0, m_pp1});
    check({tag, ".valid"},  {31'h0, valid},    {31'h0, m_valid});
    check({tag, ".halted"}, {31'h0, halted},   {31'h0, m_halt});
  endtask

  task automatic step(input logic s, input logic st, input logic b, input logic [15:0] o,
                      input logic j, input logic [25:0] t, input string tag);
    @(negedge clk);
    start = s; stall = st; br = b; off = o; jump = j; tgt = t;
    model_step();
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_pc"},     {16'h0, rom_addr}, 32'h0);
    check({tag, ".rst_instr"},  instr,             32'h0);
    check({tag, ".rst_pp1"},    {16'h0, pp1},      32'h0);
    check({tag, ".rst_valid"},  {31'h0, valid},    32'h0);
    check({tag, ".rst_halted"}, {31'h0, halted},   32'h0);
    @(negedge clk);
    start = 1'b0; stall = 1'b0; br = 1'b0; jump = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        start, stall, br;
    logic [15:0] off;
    logic        jump;
    logic [25:0] tgt;
    logic [15:0] e_pc;
    logic [31:0] e_instr;
    logic [15:0] e_pp1;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t tbl [20];
  int   halt_cnt;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h0,  32'h0,        16'h0,  1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h1,  32'h20000000, 16'h1,  1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h2,  32'h20000001, 16'h2,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h3,  32'h20000002, 16'h3,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 26'h0,       16'h3,  32'h20000002, 16'h3,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 26'h0,       16'h3,  32'h20000002, 16'h3,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 26'h0,       16'h3,  32'h20000002, 16'h3,  1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h4,  32'h20000003, 16'h4,  1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h5,  32'h20000004, 16'h5,  1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'hFFFD, 1'b0, 26'h0,       16'h2,  32'h20000004, 16'h5,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h3,  32'h20000002, 16'h3,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h4,  32'h20000003, 16'h4,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h5,  32'h20000004, 16'h5,  1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'h0,       16'h2,  32'h20000004, 16'h5,  1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b1, 26'h0000040, 16'h40, 32'h20000004, 16'h5,  1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h41, 32'h20000040, 16'h41, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 26'h3FF0006, 16'h6,  32'h20000040, 16'h41, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 26'h0,       16'h6,  32'hFC000000, 16'h7,  1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 16'h0010, 1'b1, 26'h10,      16'h6,  32'hFC000000, 16'h7,  1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'h0,       16'h6,  32'hFC000000, 16'h7,  1'b0, 1'b1};

    for (int i = 0; i < 65536; i++) rom[i] = 32'h2000_0000 + i;
    rom[6] = 32'hFC00_0000;

    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; br = 1'b0; jump = 1'b0; off = 16'h0; tgt = 26'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc",     {16'h0, rom_addr}, 32'h0);
    check("reset.instr",  instr,             32'h0);
    check("reset.pp1",    {16'h0, pp1},      32'h0);
    check("reset.valid",  {31'h0, valid},    32'h0);
    check("reset.halted", {31'h0, halted},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].start, tbl[i].stall, tbl[i].br, tbl[i].off, tbl[i].jump, tbl[i].tgt,
           $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.e_pc", i),     {16'h0, rom_addr}, {16'h0, tbl[i].e_pc});
      check($sformatf("tbl%0d.e_instr", i),  instr,             tbl[i].e_instr);
      check($sformatf("tbl%0d.e_pp1", i),    {16'h0, pp1},      {16'h0, tbl[i].e_pp1});
      check($sformatf("tbl%0d.e_valid", i),  {31'h0, valid},    {31'h0, tbl[i].e_valid});
      check($sformatf("tbl%0d.e_halted", i), {31'h0, halted},   {31'h0, tbl[i].e_halted});
    end

    // Reset out of HALT, then IDLE must hold without i_start.
    async_reset("halt_rst");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'h55, "idle0");
    step(1'b0, 1'b0, 1'b1, 16'h9,  1'b0, 26'h0,  "idle1");
    check("idle.pc", {16'h0, rom_addr}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, "go");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, "run0");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, "run1");
    async_reset("mid_rst");

    // PC wrap from 16'hFFFF.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0,    "wgo");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'hFFFF, "wjmp");
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0,    "wrap");
    check("wrap.pc",    {16'h0, rom_addr}, 32'h0);
    check("wrap.pp1",   {16'h0, pp1},      32'h0);
    check("wrap.instr", instr,             32'h2000FFFF);
    check("wrap.valid", {31'h0, valid},    32'h1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0,    "wrap1");
    check("wrap1.pc",   {16'h0, rom_addr}, 32'h1);

    // Randomised run against the model.
    for (int i = 0; i < 65536; i++) rom[i] = $urandom;
    halt_cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0 || halt_cnt > 4) begin
        async_reset("rnd_rst");
        halt_cnt = 0;
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 15) - 8),
             $urandom_range(0, 15) == 0, 26'($urandom), "rnd");
        if (m_halt) halt_cnt++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
